enc_arbiter: RTL

Round-robin arbiter that shares the 3-bit code/seven-segment display path between eight requesters. It replaces the combinational priority pick with a registered, fair grant that has a bounded hold time. It drives a one-hot grant, the winning index, and the active-low segment pattern for that index. It sits between the switch/request inputs and the board seven-segment digit.

---
 rtl/enc_arbiter_if.sv | 12 +
 rtl/enc_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/enc_arbiter_if.sv
// enc_arbiter_if: enable/request inputs and registered grant/segment outputs of enc_arbiter.
interface enc_arbiter_if;
    logic       i_en;
    logic [7:0] i_req;
    logic [7:0] o_gnt;
    logic [2:0] o_gnt_idx;
    logic       o_gnt_valid;
    logic [7:0] o_seg;

    modport master (output i_en, i_req, input  o_gnt, o_gnt_idx, o_gnt_valid, o_seg);
    modport slave  (input  i_en, i_req, output o_gnt, o_gnt_idx, o_gnt_valid, o_seg);
endinterface

// File: rtl/enc_arbiter.sv
// enc_arbiter: registered round-robin arbiter over eight requesters with bounded hold and 7-seg output.
// Define ENC_ARB_SEG_EN to build the segment decode register; otherwise o_seg is tied to 8'hFF.
module enc_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    enc_arbiter_if.slave bus
);
    localparam int unsigned       CNT_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t           r_state, w_state_nx;
    logic [2:0]       r_ptr, w_ptr_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [7:0]       r_gnt, w_gnt_nx;
    logic [2:0]       r_idx, w_idx_nx;
    logic             r_valid, w_valid_nx;
    logic [2:0]       w_win;
    logic             w_win_found;
    logic [7:0]       w_others;
    logic             w_exit;

    // First set request bit walking upward from the pointer, wrapping 7 -> 0.
    always_comb begin
        w_win       = '0;
        w_win_found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (!w_win_found && bus.i_req[r_ptr + 3'(k)]) begin
                w_win       = r_ptr + 3'(k);
                w_win_found = 1'b1;
            end
        end
    end

    assign w_others = bus.i_req & ~(8'b1 << r_idx);
    assign w_exit   = !bus.i_en || !bus.i_req[r_idx] || ((r_cnt == CNT_MAX) && (w_others != '0));

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        w_gnt_nx   = r_gnt;
        w_idx_nx   = r_idx;
        w_valid_nx = r_valid;
        case (r_state)
            S_IDLE: begin
                if (bus.i_en && w_win_found) begin
                    w_state_nx = S_GRANT;
                    w_gnt_nx   = 8'b1 << w_win;
                    w_idx_nx   = w_win;
                    w_valid_nx = 1'b1;
                    w_cnt_nx   = '0;
                end
            end
            S_GRANT: begin
                if (w_exit) begin
                    w_state_nx = S_IDLE;
                    w_gnt_nx   = '0;
                    w_valid_nx = 1'b0;
                    w_ptr_nx   = r_idx + 3'd1;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
            r_gnt   <= w_gnt_nx;
            r_idx   <= w_idx_nx;
            r_valid <= w_valid_nx;
        end
    end

    assign bus.o_gnt       = r_gnt;
    assign bus.o_gnt_idx   = r_idx;
    assign bus.o_gnt_valid = r_valid;

`ifdef ENC_ARB_SEG_EN
    logic [7:0] r_seg, w_seg_nx;

    // Decoded from next-state values so the pattern lands on the same edge as the grant.
    always_comb begin
        w_seg_nx = 8'hFF;
        if (w_valid_nx) begin
            case (w_idx_nx)
                3'd0: w_seg_nx = 8'h02;
                3'd1: w_seg_nx = 8'h9F;
                3'd2: w_seg_nx = 8'h25;
                3'd3: w_seg_nx = 8'h0D;
                3'd4: w_seg_nx = 8'h99;
                3'd5: w_seg_nx = 8'h49;
                3'd6: w_seg_nx = 8'h41;
                3'd7: w_seg_nx = 8'h1F;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg <= 8'hFF;
        end else begin
            r_seg <= w_seg_nx;
        end
    end

    assign bus.o_seg = r_seg;
`else
    assign bus.o_seg = 8'hFF;
`endif

endmodule
